writeback_stage: RTL
====================

Name: writeback_stage

Overview:
Final pipeline stage, directly downstream of the memory stage. Accepts completed instructions through a small in-order queue and retires them. Writes results to the register file through a single write port, so instructions with both a primary and a special destination retire over two cycles. Drives backpressure to the memory stage and reports each retired instruction's next RIP.

Parameters:
DEPTH, 2, queue entries; power of two, >= 2
HLT_OPCODE, 8'hF4, opcode that halts retirement

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
validIn  in  1  memory stage presents an instruction (isMemorySuccessful)
canWritebackOut  out  1  ready to upstream; transfer when validIn && canWritebackOut
currentRipIn  in  64  RIP of instruction
opcodeLengthIn  in  32  instruction length in bytes
opcodeIn  in  8  primary opcode
destRegIn  in  4  primary destination register
destRegValidIn  in  1  primary destination present
destValIn  in  64  primary result
destRegSpecialIn  in  4  special destination (e.g. RSP, RDX)
destRegSpecialValidIn  in  1  special destination present
destSpecialValIn  in  64  special result
regWrEnOut  out  1  register file write enable
regWrAddrOut  out  4  register file write address
regWrDataOut  out  64  register file write data
commitValidOut  out  1  one-cycle pulse per retired instruction
commitRipOut  out  64  next RIP of retired instruction
haltedOut  out  1  HLT retired; sticky
retiredCountOut  out  64  retired-instruction counter (see Optional Feature)

Behaviour:
- Reset (sync, active-high) clears the queue (count=0) and sets FSM=WR_PRIMARY and all outputs to 0. Queued entries are discarded; no write or commit occurs in the reset cycle or the cycle after.
- canWritebackOut = (count < DEPTH) && !haltedOut. It depends only on registered state, with no combinational path from validIn. When full, an enqueue is refused even if a pop occurs in the same cycle.
- Enqueue latches all input fields into the tail entry. Simultaneous enqueue and pop are allowed when not full, and count is unchanged.
- Latency: an entry enqueued in cycle N has its first write/commit in cycle N+1 when the queue was empty.
- Outputs regWr*, commit* and haltedOut are registered from the head entry and FSM state.
- FSM, while the queue is non-empty:
  - WR_PRIMARY:
    - If destRegValid: write destReg/destVal.
    - Else if only special is valid: write the special destination and pop.
    - If both are valid: go to WR_SPECIAL without popping.
    - Otherwise pop.
  - WR_SPECIAL: write destRegSpecial/destSpecialVal, pop, return to WR_PRIMARY.
  - No destination valid: pop with regWrEnOut=0 (1 cycle).
- commitValidOut pulses in the pop cycle. commitRipOut = currentRip + zero-extended opcodeLength, modulo 2^64 (wraps).
- Same register in primary and special: primary is written first and special second, so special wins.
- If the popped opcode == HLT_OPCODE, haltedOut is set in the commit cycle. It stays set until reset, no further entries retire, and canWritebackOut=0.
- Queue pointers wrap modulo DEPTH.
- Empty queue: regWrEnOut=0, commitValidOut=0, FSM holds WR_PRIMARY.

Optional Feature:
WB_RETIRE_COUNTER_EN: when defined, retiredCountOut is a 64-bit counter that increments on each commitValidOut, resets to 0 and wraps at 2^64. When undefined, retiredCountOut is tied to 0 and no counter flops exist.

Test Plan:
1. One instruction with dest RAX(0)=64'h1234, RIP 64'h400000, len 3 → cycle N+1: regWrEn=1, addr 0, data 64'h1234, commitValid=1, commitRip=64'h400003.
2. Dest RAX=5 and special RDX(2)=7 → writes addr0/5, then addr2/7 on consecutive cycles; single commit pulse in the second cycle.
3. Three back-to-back dual-dest instructions while validIn stays high → canWritebackOut drops to 0 when count==2; no entry lost; commits in order.
4. RIP 64'hFFFF_FFFF_FFFF_FFFE, len 4 → commitRip=64'h2.
5. HLT (8'hF4) followed by a valid instruction → haltedOut=1 at the HLT commit; the follower is never accepted; reset clears haltedOut and the queue.
6. Reset asserted mid dual-write → no write after reset; count=0, all outputs 0, retiredCountOut=0 with WB_RETIRE_COUNTER_EN.

Source files
------------

// File: rtl/writeback_stage.sv
// rtl/writeback_stage.sv - in-order retire queue with single-port register writeback; optional WB_RETIRE_COUNTER_EN
module writeback_stage #(
    parameter int          DEPTH      = 2,
    parameter logic [7:0]  HLT_OPCODE = 8'hF4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        validIn,
    output logic        canWritebackOut,
    input  logic [63:0] currentRipIn,
    input  logic [31:0] opcodeLengthIn,
    input  logic [7:0]  opcodeIn,
    input  logic [3:0]  destRegIn,
    input  logic        destRegValidIn,
    input  logic [63:0] destValIn,
    input  logic [3:0]  destRegSpecialIn,
    input  logic        destRegSpecialValidIn,
    input  logic [63:0] destSpecialValIn,
    output logic        regWrEnOut,
    output logic [3:0]  regWrAddrOut,
    output logic [63:0] regWrDataOut,
    output logic        commitValidOut,
    output logic [63:0] commitRipOut,
    output logic        haltedOut,
    output logic [63:0] retiredCountOut
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef struct packed {
        logic [63:0] rip;
        logic [31:0] len;
        logic [7:0]  opcode;
        logic [3:0]  destReg;
        logic        destRegValid;
        logic [63:0] destVal;
        logic [3:0]  destRegSpecial;
        logic        destRegSpecialValid;
        logic [63:0] destSpecialVal;
    } entry_t;

    typedef enum logic {WR_PRIMARY, WR_SPECIAL} state_t;

    entry_t         mem [DEPTH];
    logic [PW-1:0]  headPtr;
    logic [PW-1:0]  tailPtr;
    logic [PW:0]    count;
    state_t         state;
    state_t         nextState;

    entry_t         inEntry;
    entry_t         cur;
    logic           enq;
    logic           busy;
    logic           pop;
    logic           wrEn;
    logic [3:0]     wrAddr;
    logic [63:0]    wrData;

    assign canWritebackOut = (count < (PW+1)'(DEPTH)) && !haltedOut;
    assign enq             = validIn && canWritebackOut;

    assign inEntry = '{
        rip:                 currentRipIn,
        len:                 opcodeLengthIn,
        opcode:              opcodeIn,
        destReg:             destRegIn,
        destRegValid:        destRegValidIn,
        destVal:             destValIn,
        destRegSpecial:      destRegSpecialIn,
        destRegSpecialValid: destRegSpecialValidIn,
        destSpecialVal:      destSpecialValIn
    };

    // An empty queue works straight off the incoming entry so it retires the cycle after transfer.
    assign cur  = (count == '0) ? inEntry : mem[headPtr];
    assign busy = ((count != '0) || enq) && !haltedOut;

    always_comb begin
        pop       = 1'b0;
        nextState = state;
        wrEn      = 1'b0;
        wrAddr    = '0;
        wrData    = '0;
        if (busy) begin
            case (state)
                WR_PRIMARY: begin
                    if (cur.destRegValid) begin
                        wrEn   = 1'b1;
                        wrAddr = cur.destReg;
                        wrData = cur.destVal;
                        if (cur.destRegSpecialValid) nextState = WR_SPECIAL;
                        else                         pop       = 1'b1;
                    end else if (cur.destRegSpecialValid) begin
                        wrEn   = 1'b1;
                        wrAddr = cur.destRegSpecial;
                        wrData = cur.destSpecialVal;
                        pop    = 1'b1;
                    end else begin
                        pop = 1'b1;
                    end
                end
                WR_SPECIAL: begin
                    wrEn      = 1'b1;
                    wrAddr    = cur.destRegSpecial;
                    wrData    = cur.destSpecialVal;
                    pop       = 1'b1;
                    nextState = WR_PRIMARY;
                end
                default: nextState = WR_PRIMARY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (enq) mem[tailPtr] <= inEntry;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            headPtr        <= '0;
            tailPtr        <= '0;
            count          <= '0;
            state          <= WR_PRIMARY;
            regWrEnOut     <= 1'b0;
            regWrAddrOut   <= '0;
            regWrDataOut   <= '0;
            commitValidOut <= 1'b0;
            commitRipOut   <= '0;
            haltedOut      <= 1'b0;
        end else begin
            if (enq) tailPtr <= tailPtr + 1'b1;
            if (pop) headPtr <= headPtr + 1'b1;
            count          <= count + (PW+1)'(enq) - (PW+1)'(pop);
            state          <= nextState;
            regWrEnOut     <= wrEn;
            regWrAddrOut   <= wrAddr;
            regWrDataOut   <= wrData;
            commitValidOut <= pop;
            commitRipOut   <= pop ? (cur.rip + {32'b0, cur.len}) : '0;
            if (pop && (cur.opcode == HLT_OPCODE)) haltedOut <= 1'b1;
        end
    end

`ifdef WB_RETIRE_COUNTER_EN
    logic [63:0] retiredCount;

    always_ff @(posedge clk) begin
        if (reset)    retiredCount <= '0;
        else if (pop) retiredCount <= retiredCount + 64'd1;
    end

    assign retiredCountOut = retiredCount;
`else
    assign retiredCountOut = '0;
`endif

endmodule
